fat_chain_server: RTL and testbench

FAT_CHAIN_SERVER -- requirements
Module: fat_chain_server

---
 rtl/fs_pkg.sv | 16 +
 rtl/fat_entry_locator.sv | 30 +++
 rtl/fat_chain_server.sv | 166 ++++++++++++++++
 tb/tb_fat_chain_server.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fs_pkg.sv
// Shared constants and types for the FAT cluster-chain writer.
package fs_pkg;

    localparam logic [31:0] EOF_MARK        = 32'h0FFF_FFFF;
    localparam int unsigned DEF_BLOCK_SHIFT = 9;
    localparam int unsigned DEF_ENTRY_SHIFT = 7;
    localparam int unsigned COPY_W          = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/fat_entry_locator.sv
// Maps a cluster number and FAT copy index to the FAT sector and entry offset.
module fat_entry_locator
    import fs_pkg::*;
#(
    parameter int unsigned ENTRY_SHIFT = DEF_ENTRY_SHIFT
) (
    input  logic [31:0]             cluster,
    input  logic [COPY_W-1:0]       copy_idx,
    input  logic [31:0]             fat1_begin,
    input  logic [31:0]             fat_size,
    output logic [31:0]             sector_c,
    output logic [ENTRY_SHIFT-1:0]  offset_c
);

    logic [31:0] copy_base;

    // copy_idx * fat_size for copies 0..3 using shifts and one add
    always_comb begin
        copy_base = '0;
        case (copy_idx)
            COPY_W'(1): copy_base = fat_size;
            COPY_W'(2): copy_base = fat_size << 1;
            COPY_W'(3): copy_base = (fat_size << 1) + fat_size;
            default:    copy_base = '0;
        endcase
        sector_c = fat1_begin + copy_base + (cluster >> ENTRY_SHIFT);
        offset_c = cluster[ENTRY_SHIFT-1:0];
    end

endmodule

// File: rtl/fat_chain_server.sv
// Writes the FAT cluster chain of a contiguous file into every FAT copy.
module fat_chain_server
    import fs_pkg::*;
#(
    parameter int unsigned NUM_FATS    = 2,
    parameter int unsigned BLOCK_SHIFT = DEF_BLOCK_SHIFT,
    parameter int unsigned ENTRY_SHIFT = DEF_ENTRY_SHIFT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic [31:0]             first_file_block,
    input  logic [31:0]             fat1_begin,
    input  logic [31:0]             fat_size,
    input  logic [4:0]              clust_shift,
    input  logic [31:0]             start_clust,
    input  logic [31:0]             stop_block_num,
    output logic                    wr_valid,
    input  logic                    wr_ready,
    output logic [31:0]             wr_sector,
    output logic [ENTRY_SHIFT-1:0]  wr_offset,
    output logic [31:0]             wr_value,
    output logic                    busy,
    output logic                    complt,
    output logic                    err,
    output logic [31:0]             file_size_bytes,
    output logic [31:0]             clust_num_eof,
    output logic [31:0]             addr_to_resume
);

    localparam int unsigned W = 32;
    localparam logic [COPY_W-1:0] LAST_COPY = COPY_W'(NUM_FATS - 1);

    state_t              state;
    logic [W-1:0]        clust_q;
    logic [COPY_W-1:0]   copy_q;
    logic [W-1:0]        fat1_q;
    logic [W-1:0]        fat_size_q;

    logic [W-1:0]        n_blocks_c;
    logic [W-1:0]        eof_calc_c;
    logic                empty_c;
    logic                last_entry_c;

    logic [W-1:0]        loc_clust;
    logic [COPY_W-1:0]   loc_copy;
    logic [W-1:0]        loc_fat1;
    logic [W-1:0]        loc_fat_size;
    logic [W-1:0]        loc_eof;
    logic [W-1:0]        loc_value;
    logic [W-1:0]        loc_sector_c;
    logic [ENTRY_SHIFT-1:0] loc_offset_c;

    // Chain geometry from the live inputs, only consumed in CALC
    always_comb begin
        n_blocks_c = stop_block_num - first_file_block;
        empty_c    = (stop_block_num <= first_file_block);
        eof_calc_c = start_clust + ((n_blocks_c - W'(1)) >> clust_shift);
    end

    // Next entry to present: the first one while in CALC, else the successor of the current one
    always_comb begin
        loc_clust    = clust_q;
        loc_copy     = copy_q + COPY_W'(1);
        loc_fat1     = fat1_q;
        loc_fat_size = fat_size_q;
        loc_eof      = clust_num_eof;
        if (state == CALC) begin
            loc_clust    = start_clust;
            loc_copy     = '0;
            loc_fat1     = fat1_begin;
            loc_fat_size = fat_size;
            loc_eof      = eof_calc_c;
        end else if (copy_q == LAST_COPY) begin
            loc_clust = clust_q + W'(1);
            loc_copy  = '0;
        end
        loc_value = (loc_clust == loc_eof) ? EOF_MARK : loc_clust + W'(1);
    end

    assign last_entry_c = (clust_q == clust_num_eof) && (copy_q == LAST_COPY);

    fat_entry_locator #(
        .ENTRY_SHIFT (ENTRY_SHIFT)
    ) u_locator (
        .cluster    (loc_clust),
        .copy_idx   (loc_copy),
        .fat1_begin (loc_fat1),
        .fat_size   (loc_fat_size),
        .sector_c   (loc_sector_c),
        .offset_c   (loc_offset_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            clust_q         <= '0;
            copy_q          <= '0;
            fat1_q          <= '0;
            fat_size_q      <= '0;
            wr_valid        <= 1'b0;
            wr_sector       <= '0;
            wr_offset       <= '0;
            wr_value        <= '0;
            busy            <= 1'b0;
            complt          <= 1'b0;
            err             <= 1'b0;
            file_size_bytes <= '0;
            clust_num_eof   <= '0;
            addr_to_resume  <= '0;
        end else begin
            complt <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (ena) begin
                        state <= CALC;
                        busy  <= 1'b1;
                    end
                end
                CALC: begin
                    fat1_q         <= fat1_begin;
                    fat_size_q     <= fat_size;
                    clust_q        <= start_clust;
                    copy_q         <= '0;
                    addr_to_resume <= stop_block_num;
                    err            <= empty_c;
                    if (empty_c) begin
                        file_size_bytes <= '0;
                        clust_num_eof   <= start_clust;
                        complt          <= 1'b1;
                        state           <= DONE;
                    end else begin
                        file_size_bytes <= n_blocks_c << BLOCK_SHIFT;
                        clust_num_eof   <= eof_calc_c;
                        wr_valid        <= 1'b1;
                        wr_sector       <= loc_sector_c;
                        wr_offset       <= loc_offset_c;
                        wr_value        <= loc_value;
                        state           <= EMIT;
                    end
                end
                EMIT: begin
                    if (wr_ready) begin
                        if (last_entry_c) begin
                            wr_valid <= 1'b0;
                            complt   <= 1'b1;
                            state    <= DONE;
                        end else begin
                            clust_q   <= loc_clust;
                            copy_q    <= loc_copy;
                            wr_sector <= loc_sector_c;
                            wr_offset <= loc_offset_c;
                            wr_value  <= loc_value;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fat_chain_server.sv
// Bench for fat_chain_server: directed vectors, stalls, reset abort and randomized jobs vs a chain model.
module tb_fat_chain_server;
    import fs_pkg::*;

    localparam int unsigned ES = 7;

    typedef struct packed {
        logic [31:0]   sector;
        logic [ES-1:0] offset;
        logic [31:0]   value;
    } ent_t;

    typedef struct {
        logic [31:0] first;
        logic [31:0] fat1;
        logic [31:0] fsz;
        logic [4:0]  cshift;
        logic [31:0] start;
        logic [31:0] stop;
        logic [31:0] exp_size;
        logic [31:0] exp_eof;
        logic        exp_err;
        int          exp_nwr;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n, ena, wr_ready;
    logic [31:0] first_file_block, fat1_begin, fat_size, start_clust, stop_block_num;
    logic [4:0]  clust_shift;

    logic wr_valid0, busy0, complt0, err0;
    logic [31:0] wr_sector0, wr_value0, fsb0, eof0, atr0;
    logic [ES-1:0] wr_offset0;
    logic wr_valid1, busy1, complt1, err1;
    logic [31:0] wr_sector1, wr_value1, fsb1, eof1, atr1;
    logic [ES-1:0] wr_offset1;

    int checks = 0;
    int errors = 0;

    ent_t exp_q0[$];
    ent_t exp_q1[$];
    ent_t got0[$];
    ent_t got1[$];
    logic [31:0] m_size, m_eof, m_stop;
    logic        m_err;
    bit   done_f[2];
    int   done_cyc[2];
    bit   prev_stall[2];
    ent_t prev_ent[2];

    always #5 clk = ~clk;

    fat_chain_server #(.NUM_FATS(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .first_file_block(first_file_block), .fat1_begin(fat1_begin), .fat_size(fat_size),
        .clust_shift(clust_shift), .start_clust(start_clust), .stop_block_num(stop_block_num),
        .wr_valid(wr_valid0), .wr_ready(wr_ready), .wr_sector(wr_sector0), .wr_offset(wr_offset0),
        .wr_value(wr_value0), .busy(busy0), .complt(complt0), .err(err0),
        .file_size_bytes(fsb0), .clust_num_eof(eof0), .addr_to_resume(atr0)
    );

    fat_chain_server #(.NUM_FATS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .first_file_block(first_file_block), .fat1_begin(fat1_begin), .fat_size(fat_size),
        .clust_shift(clust_shift), .start_clust(start_clust), .stop_block_num(stop_block_num),
        .wr_valid(wr_valid1), .wr_ready(wr_ready), .wr_sector(wr_sector1), .wr_offset(wr_offset1),
        .wr_value(wr_value1), .busy(busy1), .complt(complt1), .err(err1),
        .file_size_bytes(fsb1), .clust_num_eof(eof1), .addr_to_resume(atr1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected chain from the file geometry: ceil(N / blocks_per_cluster) clusters, every FAT copy each
    task automatic build_model();
        logic [31:0] n, nclus, c;
        ent_t e;
        exp_q0.delete();
        exp_q1.delete();
        m_stop = stop_block_num;
        m_err  = (stop_block_num <= first_file_block);
        if (m_err) begin
            m_size = 32'd0;
            m_eof  = start_clust;
        end else begin
            n      = stop_block_num - first_file_block;
            m_size = n * 32'd512;
            nclus  = (n - 32'd1) / (32'd1 << clust_shift) + 32'd1;
            m_eof  = start_clust + nclus - 32'd1;
            for (int k = 0; k < int'(nclus); k++) begin
                c = start_clust + 32'(k);
                for (int cp = 0; cp < 2; cp++) begin
                    e.sector = fat1_begin + 32'(cp) * fat_size + c / 32'd128;
                    e.offset = ES'(c % 32'd128);
                    e.value  = (k == int'(nclus) - 1) ? EOF_MARK : c + 32'd1;
                    exp_q0.push_back(e);
                    if (cp == 0) exp_q1.push_back(e);
                end
            end
        end
    endtask

    task automatic observe(input int id, input logic v, input ent_t cur, input logic cp,
                           input logic by, input logic er, input logic [31:0] fsb,
                           input logic [31:0] eofv, input logic [31:0] atr, input int cyc);
        ent_t e;
        bit   empty_q;
        if (done_f[id]) begin
            chk($sformatf("dut%0d_quiet_after_done", id), {30'd0, cp, v}, 32'd0);
            return;
        end
        if (v && prev_stall[id]) begin
            chk($sformatf("dut%0d_stall_sector", id), cur.sector, prev_ent[id].sector);
            chk($sformatf("dut%0d_stall_offset", id), 32'(cur.offset), 32'(prev_ent[id].offset));
            chk($sformatf("dut%0d_stall_value", id), cur.value, prev_ent[id].value);
        end
        if (v && wr_ready) begin
            empty_q = (id == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
            if (empty_q) begin
                checks++;
                errors++;
                $display("FAIL dut%0d_extra_write: got sector 0x%08h, expected no write", id, cur.sector);
            end else begin
                if (id == 0) begin e = exp_q0.pop_front(); got0.push_back(cur); end
                else         begin e = exp_q1.pop_front(); got1.push_back(cur); end
                chk($sformatf("dut%0d_wr_sector", id), cur.sector, e.sector);
                chk($sformatf("dut%0d_wr_offset", id), 32'(cur.offset), 32'(e.offset));
                chk($sformatf("dut%0d_wr_value", id), cur.value, e.value);
            end
        end
        prev_stall[id] = v && !wr_ready;
        prev_ent[id]   = cur;
        if (cp) begin
            done_f[id]   = 1'b1;
            done_cyc[id] = cyc;
            chk($sformatf("dut%0d_busy_in_done", id), 32'(by), 32'd1);
            chk($sformatf("dut%0d_err", id), 32'(er), 32'(m_err));
            chk($sformatf("dut%0d_file_size", id), fsb, m_size);
            chk($sformatf("dut%0d_clust_eof", id), eofv, m_eof);
            chk($sformatf("dut%0d_resume", id), atr, m_stop);
            chk($sformatf("dut%0d_missing_writes", id),
                (id == 0) ? 32'(exp_q0.size()) : 32'(exp_q1.size()), 32'd0);
        end
    endtask

    // mode 0: ready always high; 1: random ready; 2: ready low 5 cycles after 2 accepts
    task automatic run_job(input int mode);
        int cyc, stall_cnt;
        build_model();
        got0.delete();
        got1.delete();
        for (int i = 0; i < 2; i++) begin
            done_f[i] = 1'b0; done_cyc[i] = -1; prev_stall[i] = 1'b0; prev_ent[i] = '0;
        end
        stall_cnt = 0;
        @(negedge clk);
        ena      = 1'b1;
        wr_ready = 1'b1;
        cyc      = 0;
        while (!(done_f[0] && done_f[1]) && cyc < 2000) begin
            @(negedge clk);
            ena = 1'b0;
            cyc++;
            if (cyc == 2) begin
                first_file_block = $urandom; fat1_begin = $urandom; fat_size = $urandom;
                clust_shift = 5'($urandom); start_clust = $urandom; stop_block_num = $urandom;
            end
            case (mode)
                1: wr_ready = ($urandom_range(0, 2) != 0);
                2: begin
                    if (got0.size() >= 2 && stall_cnt < 5) begin
                        wr_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        wr_ready = 1'b1;
                    end
                end
                default: wr_ready = 1'b1;
            endcase
            #1;
            observe(0, wr_valid0, {wr_sector0, wr_offset0, wr_value0}, complt0, busy0, err0,
                    fsb0, eof0, atr0, cyc);
            observe(1, wr_valid1, {wr_sector1, wr_offset1, wr_value1}, complt1, busy1, err1,
                    fsb1, eof1, atr1, cyc);
        end
        if (cyc >= 2000) begin
            checks++;
            errors++;
            $display("FAIL job_timeout: no completion within %0d cycles", cyc);
        end
        @(negedge clk);
        #1;
        chk("idle_after_done", {28'd0, busy0, complt0, busy1, complt1}, 32'd0);
    endtask

    task automatic set_inputs(input vec_t v);
        first_file_block = v.first; fat1_begin = v.fat1; fat_size = v.fsz;
        clust_shift = v.cshift; start_clust = v.start; stop_block_num = v.stop;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl0"}, {28'd0, wr_valid0, busy0, complt0, err0}, 32'd0);
        chk({tag, "_ctl1"}, {28'd0, wr_valid1, busy1, complt1, err1}, 32'd0);
        chk({tag, "_sector"}, wr_sector0 | wr_sector1, 32'd0);
        chk({tag, "_offset"}, 32'(wr_offset0 | wr_offset1), 32'd0);
        chk({tag, "_value"}, wr_value0 | wr_value1, 32'd0);
        chk({tag, "_results"}, fsb0 | eof0 | atr0 | fsb1 | eof1 | atr1, 32'd0);
    endtask

    initial begin
        vec_t vecs[5];
        logic [31:0] h_sec[6];
        logic [31:0] h_off[6];
        logic [31:0] h_val[6];
        vecs[0] = '{32'd16448, 32'd14462, 32'd961, 5'd6, 32'd2,   32'd16578, 32'd66560, 32'd4,   1'b0, 6};
        vecs[1] = '{32'd16448, 32'd14462, 32'd961, 5'd6, 32'd2,   32'd16448, 32'd0,     32'd2,   1'b1, 0};
        vecs[2] = '{32'd16448, 32'd14462, 32'd961, 5'd6, 32'd126, 32'd16640, 32'd98304, 32'd128, 1'b0, 6};
        vecs[3] = '{32'd100,   32'd1000,  32'd50,  5'd0, 32'd5,   32'd101,   32'd512,   32'd5,   1'b0, 2};
        vecs[4] = '{32'd200,   32'd1000,  32'd50,  5'd2, 32'd7,   32'd100,   32'd0,     32'd7,   1'b1, 0};
        h_sec = '{32'd14462, 32'd15423, 32'd14462, 32'd15423, 32'd14462, 32'd15423};
        h_off = '{32'd2, 32'd2, 32'd3, 32'd3, 32'd4, 32'd4};
        h_val = '{32'd3, 32'd3, 32'd4, 32'd4, EOF_MARK, EOF_MARK};

        rst_n = 1'b0; ena = 1'b0; wr_ready = 1'b1;
        set_inputs(vecs[0]);
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            set_inputs(vecs[i]);
            run_job(0);
            chk($sformatf("vec%0d_size", i), fsb0, vecs[i].exp_size);
            chk($sformatf("vec%0d_eof", i), eof0, vecs[i].exp_eof);
            chk($sformatf("vec%0d_err", i), 32'(err0), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_resume", i), atr0, vecs[i].stop);
            chk($sformatf("vec%0d_nwr", i), 32'(got0.size()), 32'(vecs[i].exp_nwr));
            chk($sformatf("vec%0d_nwr_1fat", i), 32'(got1.size()), 32'(vecs[i].exp_nwr / 2));
            chk($sformatf("vec%0d_complt_cycle", i), 32'(done_cyc[0]), 32'(2 + vecs[i].exp_nwr));
            if (i == 0 && got0.size() == 6) begin
                for (int k = 0; k < 6; k++) begin
                    chk($sformatf("ex035_sector%0d", k), got0[k].sector, h_sec[k]);
                    chk($sformatf("ex035_offset%0d", k), 32'(got0[k].offset), h_off[k]);
                    chk($sformatf("ex035_value%0d", k), got0[k].value, h_val[k]);
                end
            end
            if (i == 2 && got0.size() == 6) begin
                chk("ex037_c0_sector", got0[4].sector, 32'd14463);
                chk("ex037_c1_sector", got0[5].sector, 32'd15424);
                chk("ex037_offset", 32'(got0[4].offset | got0[5].offset), 32'd0);
                chk("ex037_value", got0[5].value, EOF_MARK);
            end
        end

        set_inputs(vecs[0]);
        run_job(2);
        chk("stall_nwr", 32'(got0.size()), 32'd6);

        // Reset in the middle of EMIT, then a fresh run
        set_inputs(vecs[0]);
        @(negedge clk); ena = 1'b1;
        @(negedge clk); ena = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("pre_abort_valid", {30'd0, wr_valid0, busy0}, 32'd3);
        #1 rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        set_inputs(vecs[0]);
        run_job(0);
        chk("rerun_nwr", 32'(got0.size()), 32'd6);
        chk("rerun_complt_cycle", 32'(done_cyc[0]), 32'd8);
        if (got0.size() > 0) chk("rerun_first_value", got0[0].value, 32'd3);

        for (int j = 0; j < 30; j++) begin
            logic [31:0] n;
            first_file_block = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 20) : $urandom;
            start_clust      = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 8) : $urandom;
            fat1_begin       = $urandom;
            fat_size         = $urandom;
            clust_shift      = 5'($urandom_range(0, 3));
            n                = 32'($urandom_range(0, 40));
            stop_block_num   = ($urandom_range(0, 9) == 0) ? first_file_block - n : first_file_block + n;
            run_job(1 + (j % 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
